bcd_serial_adder: RTL and testbench



---
 rtl/bcd_pkg.sv | 30 +++
 rtl/bcd_digit_add.sv | 14 +
 rtl/bcd_serial_adder.sv | 121 ++++++++++++
 tb/tb_bcd_serial_adder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types, constants and the single-digit decimal add rule for the serial BCD adder.
package bcd_pkg;

    localparam int         DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_ADJ = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns {carry_out, digit}. Sums above 9 are pushed past 15 by +6 so the low nibble wraps
    // to the correct decimal digit.
    function automatic logic [4:0] bcd_digit_sum(
        input logic [DIGIT_W-1:0] a,
        input logic [DIGIT_W-1:0] b,
        input logic               c
    );
        logic [4:0] t;
        t = {1'b0, a} + {1'b0, b} + {4'b0000, c};
        if (t > {1'b0, BCD_MAX}) begin
            t = t + {1'b0, BCD_ADJ};
            return {1'b1, t[3:0]};
        end
        return {1'b0, t[3:0]};
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational one-digit packed-BCD adder with decimal carry in and out.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] d,
    output logic               cout
);

    assign {cout, d} = bcd_digit_sum(a, b, cin);

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one decimal digit per cycle, LSB first, valid/ready on both sides.
// Optional BCD_INPUT_CHECK_EN adds a sticky err output flagging non-BCD operand digits.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DIGIT_W*NDIGITS-1:0] a,
    input  logic [DIGIT_W*NDIGITS-1:0] b,
    input  logic                       cin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DIGIT_W*NDIGITS-1:0] sum,
    output logic                       cout,
    output state_t                     state_dbg,
    output logic                       busy
`ifdef BCD_INPUT_CHECK_EN
    ,
    output logic                       err
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and data is held stable while valid is high and ready is low.

    localparam int W  = DIGIT_W * NDIGITS;
    localparam int IW = $clog2(NDIGITS) + 1;

    state_t               state;
    logic [IW-1:0]        idx;
    logic [W-1:0]         a_q;
    logic [W-1:0]         b_q;
    logic                 carry;
    logic [DIGIT_W-1:0]   a_dig;
    logic [DIGIT_W-1:0]   b_dig;
    logic [DIGIT_W-1:0]   d;
    logic                 c;

    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx == IW'(i)) begin
                a_dig = a_q[i*DIGIT_W +: DIGIT_W];
                b_dig = b_q[i*DIGIT_W +: DIGIT_W];
            end
        end
    end

    bcd_digit_add u_digit (
        .a    (a_dig),
        .b    (b_dig),
        .cin  (carry),
        .d    (d),
        .cout (c)
    );

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
`ifdef BCD_INPUT_CHECK_EN
            err       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= cin;
                        idx   <= '0;
                        sum   <= '0;
                        state <= RUN;
`ifdef BCD_INPUT_CHECK_EN
                        err   <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    for (int i = 0; i < NDIGITS; i++) begin
                        if (idx == IW'(i)) sum[i*DIGIT_W +: DIGIT_W] <= d;
                    end
                    carry <= c;
                    idx   <= idx + 1'b1;
`ifdef BCD_INPUT_CHECK_EN
                    if (a_dig > BCD_MAX || b_dig > BCD_MAX) err <= 1'b1;
`endif
                    if (idx == IW'(NDIGITS - 1)) begin
                        cout      <= c;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Result stays frozen until the consumer takes it.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder: driver tasks push expected {err,cout,sum}, a monitor pops on handshake.
module tb_bcd_serial_adder;
    import bcd_pkg::*;

    localparam int NDIGITS = 4;
    localparam int W       = 4 * NDIGITS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    state_t       state_dbg;
    logic         busy;
`ifdef BCD_INPUT_CHECK_EN
    logic         err;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;
    logic prev_ov = 1'b0;
    logic [W+1:0] exp_q[$];

    bcd_serial_adder #(.NDIGITS(NDIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .state_dbg (state_dbg),
        .busy      (busy)
`ifdef BCD_INPUT_CHECK_EN
        ,
        .err       (err)
`endif
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [W+1:0] e;
        if (rst_n) begin
            if (out_valid && !prev_ov) check("latency", cyc - accept_cyc, NDIGITS);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: sum %h cout %b but nothing expected", sum, cout);
                end else begin
                    e = exp_q.pop_front();
                    check("sum", 32'(sum), 32'(e[W-1:0]));
                    check("cout", 32'(cout), 32'(e[W]));
`ifdef BCD_INPUT_CHECK_EN
                    check("err", 32'(err), 32'(e[W+1]));
`endif
                end
            end
        end
        prev_ov = out_valid;
    end

    // Driver tasks
    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                        input logic [W+1:0] exp, input bit push);
        int n = 0;
        in_valid = 1'b1;
        a = va;
        b = vb;
        cin = vc;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready %b required 1", in_ready);
        end
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
    endtask

    task automatic wait_out();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL out_timeout: out_valid %b required 1", out_valid);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(in_ready && exp_q.size() == 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!(in_ready && exp_q.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: in_ready %b pending %0d", in_ready, exp_q.size());
        end
    endtask

    initial begin
        int seen;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_cout", 32'(cout), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain adds with hand-computed results
        send(16'h1234, 16'h5678, 1'b0, {2'b00, 16'h6912}, 1'b1);
        in_valid = 1'b0;
        check("run_state", 32'(state_dbg), 32'(RUN));
        check("run_busy", 32'(busy), 1);
        check("run_in_ready", 32'(in_ready), 0);
        wait_idle();
        send(16'h9999, 16'h0001, 1'b0, {2'b01, 16'h0000}, 1'b1);
        in_valid = 1'b0;
        wait_idle();
        send(16'h0000, 16'h0000, 1'b1, {2'b00, 16'h0001}, 1'b1);
        in_valid = 1'b0;
        wait_idle();
        send(16'h9999, 16'h0000, 1'b1, {2'b01, 16'h0000}, 1'b1);
        in_valid = 1'b0;
        wait_idle();
        send(16'h0909, 16'h0191, 1'b0, {2'b00, 16'h1100}, 1'b1);
        in_valid = 1'b0;
        wait_idle();

        // Back-pressure: hold result three cycles while new operands are offered
        out_ready = 1'b0;
        send(16'h8765, 16'h4321, 1'b0, {2'b01, 16'h3086}, 1'b1);
        in_valid = 1'b0;
        wait_out();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 16'h0001;
            b = 16'h0001;
            check("bp_sum", 32'(sum), 32'h3086);
            check("bp_cout", 32'(cout), 1);
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_state", 32'(state_dbg), 32'(DONE));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(16'h0001, 16'h0001, 1'b0, {2'b00, 16'h0002}, 1'b1);
        in_valid = 1'b0;
        wait_idle();

        // Reset on the second RUN cycle abandons the add
        send(16'h5555, 16'h5555, 1'b0, '0, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid_rst_state", 32'(state_dbg), 32'(IDLE));
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_sum", 32'(sum), 0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mid_rst_no_result", seen, 0);

        // Back-to-back with in_valid held high
        send(16'h0500, 16'h0500, 1'b0, {2'b00, 16'h1000}, 1'b1);
        send(16'h0001, 16'h0009, 1'b0, {2'b00, 16'h0010}, 1'b1);
        in_valid = 1'b0;
        wait_idle();

`ifdef BCD_INPUT_CHECK_EN
        send(16'h00A0, 16'h0000, 1'b0, {2'b10, 16'h0100}, 1'b1);
        in_valid = 1'b0;
        wait_idle();
        send(16'h0001, 16'h0002, 1'b0, {2'b00, 16'h0003}, 1'b1);
        in_valid = 1'b0;
        wait_idle();
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
